// File: rtl/flatten_fc_ibuf.sv
// Pixel input buffer feeding bit-serial slices of the flattened image to the FC CIM tiles.
// Define FLATTEN_IBUF_PING_PONG_EN for two alternating banks; default is a single bank.
module flatten_fc_ibuf #(
  parameter int DATA_SIZE       = 8,
  parameter int INPUT_CHANNELS  = 16,
  parameter int IMG_SIZE        = 784,
  parameter int XBAR_SIZE       = 128,
  parameter int BUS_WIDTH       = 16,
  parameter int V_CIM_TILES_OUT = (INPUT_CHANNELS * IMG_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  parameter int NUM_ADDR        = (XBAR_SIZE + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int ADDR_WIDTH      = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
  parameter int COUNT_WIDTH     = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
  parameter int PIX_WIDTH       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [INPUT_CHANNELS*DATA_SIZE-1:0]    i_data,
  output logic                                   o_pixel_stb,
  output logic                                   o_full,
  input  logic                                   i_rd_en,
  input  logic [ADDR_WIDTH-1:0]                  i_addr,
  input  logic [COUNT_WIDTH-1:0]                 i_count,
  output logic [BUS_WIDTH*V_CIM_TILES_OUT-1:0]   o_data,
  input  logic                                   i_release,
  output logic [PIX_WIDTH-1:0]                   o_pix_cnt
);

  // state | meaning
  // FILL  | bank accepting pixels, not readable
  // FULL  | bank holds a complete image, readable until released

  localparam int NUM_ELEM = INPUT_CHANNELS * IMG_SIZE;
  localparam int OUT_W    = BUS_WIDTH * V_CIM_TILES_OUT;
`ifdef FLATTEN_IBUF_PING_PONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  state_e                st_q [NBANK];
  logic                  wr_q;
  logic                  rd_q;
  logic [PIX_WIDTH-1:0]  pix_q;
  logic                  stb_q;
  logic [OUT_W-1:0]      data_q;
  logic [OUT_W-1:0]      data_d;
  logic [DATA_SIZE-1:0]  mem_q [NBANK][NUM_ELEM];

  logic accept;
  logic rd_fire;
  logic release_fire;
  logic last_pix;

  assign o_ready      = rst && (st_q[wr_q] == FILL);
  assign accept       = i_valid && o_ready;
  assign rd_fire      = i_rd_en && (st_q[rd_q] == FULL);
  assign release_fire = i_release && (st_q[rd_q] == FULL);
  assign last_pix     = (pix_q == PIX_WIDTH'(IMG_SIZE - 1));

  assign o_full      = (st_q[rd_q] == FULL);
  assign o_pixel_stb = stb_q;
  assign o_data      = data_q;
  assign o_pix_cnt   = pix_q;

  // Banks are filled and read in strict alternation, so write and release never hit the same bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < NBANK; b++) st_q[b] <= FILL;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      pix_q  <= '0;
      stb_q  <= 1'b0;
      data_q <= '0;
    end else begin
      stb_q <= accept;
      if (rd_fire) data_q <= data_d;
      if (accept) begin
        if (last_pix) begin
          pix_q      <= '0;
          st_q[wr_q] <= FULL;
`ifdef FLATTEN_IBUF_PING_PONG_EN
          wr_q       <= ~wr_q;
`endif
        end else begin
          pix_q <= pix_q + 1'b1;
        end
      end
      if (release_fire) begin
        st_q[rd_q] <= FILL;
`ifdef FLATTEN_IBUF_PING_PONG_EN
        rd_q       <= ~rd_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < INPUT_CHANNELS; c++)
        mem_q[wr_q][int'(pix_q) * INPUT_CHANNELS + c] <= i_data[c*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Element index is pixel-major; rows beyond the crossbar or image read as zero.
  always_comb begin
    data_d = '0;
    for (int t = 0; t < V_CIM_TILES_OUT; t++) begin
      for (int j = 0; j < BUS_WIDTH; j++) begin
        int row;
        int e;
        row = int'(i_addr) * BUS_WIDTH + j;
        e   = t * XBAR_SIZE + row;
        if ((int'(i_addr) < NUM_ADDR) && (row < XBAR_SIZE) && (e < NUM_ELEM))
          data_d[t*BUS_WIDTH + j] = mem_q[rd_q][e][i_count];
      end
    end
  end

endmodule

// File: tb/tb_flatten_fc_ibuf.sv
// Directed self-checking bench for flatten_fc_ibuf (default single-bank build, ping-pong path under its macro).
module tb_flatten_fc_ibuf;

  localparam int DS   = 8;
  localparam int CH   = 16;
  localparam int IMG  = 784;
  localparam int XB   = 128;
  localparam int BW   = 16;
  localparam int VT   = 98;
  localparam int NE   = CH * IMG;
  localparam int OW   = BW * VT;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [CH*DS-1:0]  i_data;
  logic              o_pixel_stb;
  logic              o_full;
  logic              i_rd_en;
  logic [2:0]        i_addr;
  logic [2:0]        i_count;
  logic [OW-1:0]     o_data;
  logic              i_release;
  logic [9:0]        o_pix_cnt;

  int total = 0;
  int bad = 0;
  int stb_seen = 0;

  flatten_fc_ibuf dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_pixel_stb(o_pixel_stb), .o_full(o_full), .i_rd_en(i_rd_en), .i_addr(i_addr),
    .i_count(i_count), .o_data(o_data), .i_release(i_release), .o_pix_cnt(o_pix_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] val(int img, int e);
    int x;
    x = (img == 0) ? e : (e * 7 + 3);
    return x[7:0];
  endfunction

  function automatic logic [CH*DS-1:0] pix(int img, int p);
    logic [CH*DS-1:0] d;
    for (int c = 0; c < CH; c++) d[c*DS +: DS] = val(img, p * CH + c);
    return d;
  endfunction

  function automatic logic [OW-1:0] model(int img, int addr, int cnt);
    logic [OW-1:0] m;
    logic [7:0] v;
    m = '0;
    for (int t = 0; t < VT; t++)
      for (int j = 0; j < BW; j++) begin
        int row;
        int e;
        row = addr * BW + j;
        e = t * XB + row;
        if (addr < 8 && row < XB && e < NE) begin
          v = val(img, e);
          m[t*BW + j] = v[cnt];
        end
      end
    return m;
  endfunction

  task automatic check(string tag, logic [OW-1:0] got, logic [OW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h diffbits=%0d", tag, got[63:0], exp[63:0], $countones(got ^ exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(int img, int start, int n);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'b1;
      i_data  = pix(img, start + k);
      tick();
      if (o_pixel_stb) stb_seen++;
    end
    i_valid = 1'b0;
  endtask

  task automatic rd(int a, int c);
    i_rd_en = 1'b1;
    i_addr  = 3'(a);
    i_count = 3'(c);
    tick();
    i_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_data = '0; i_rd_en = 1'b0;
    i_addr = '0; i_count = '0; i_release = 1'b0;
    tick(); tick();
    check("rst_ready", o_ready, 0);
    check("rst_full", o_full, 0);
    check("rst_pixcnt", o_pix_cnt, 0);
    check("rst_stb", o_pixel_stb, 0);
    check("rst_data", o_data, 0);
    rst = 1'b1;
    #1;
    check("ready_after_rst", o_ready, 1);

    fill(0, 0, IMG - 1);
    check("pixcnt_783", o_pix_cnt, 783);
    check("not_full_783", o_full, 0);
    fill(0, IMG - 1, 1);
    check("full_after_fill", o_full, 1);
    check("pixcnt_wrap", o_pix_cnt, 0);
    check("stb_count", stb_seen, IMG);
    tick();
    check("stb_drop", o_pixel_stb, 0);

    rd(0, 0);
    check("tile0_lsb", o_data[15:0], 16'hAAAA);
    check("rd_0_0", o_data, model(0, 0, 0));
    for (int a = 0; a < 8; a++)
      for (int c = 0; c < 8; c++) begin
        i_rd_en = 1'b1; i_addr = 3'(a); i_count = 3'(c);
        tick();
        check("sweep", o_data, model(0, a, c));
      end
    i_rd_en = 1'b0; i_addr = 3'd3; i_count = 3'd5;
    tick();
    check("rd_hold", o_data, model(0, 7, 7));

`ifndef FLATTEN_IBUF_PING_PONG_EN
    check("full_not_ready", o_ready, 0);
    i_valid = 1'b1; i_data = pix(1, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("full_no_stb", o_pixel_stb, 0);
      check("full_no_cnt", o_pix_cnt, 0);
    end
    i_release = 1'b1; i_rd_en = 1'b1; i_addr = 3'd2; i_count = 3'd6;
    tick();
    i_release = 1'b0; i_rd_en = 1'b0;
    check("rel_read", o_data, model(0, 2, 6));
    check("rel_full", o_full, 0);
    check("rel_ready", o_ready, 1);
    check("rel_cnt", o_pix_cnt, 0);
    tick();
    check("first_acc_stb", o_pixel_stb, 1);
    check("first_acc_cnt", o_pix_cnt, 1);
    fill(1, 1, 299);
    check("cnt_300", o_pix_cnt, 300);
    rd(4, 4);
    check("fill_rd_ignored", o_data, model(0, 2, 6));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_cnt", o_pix_cnt, 0);
    check("midrst_full", o_full, 0);
    check("midrst_data", o_data, 0);
    stb_seen = 0;
    fill(1, 0, IMG);
    check("refill_full", o_full, 1);
    check("refill_stb", stb_seen, IMG);
    rd(0, 0);
    check("b_rd_0_0", o_data, model(1, 0, 0));
    rd(7, 7);
    check("b_rd_7_7", o_data, model(1, 7, 7));
    rd(4, 3);
    check("b_rd_4_3", o_data, model(1, 4, 3));
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    check("final_rel_full", o_full, 0);
`else
    check("pp_ready_a_full", o_ready, 1);
    stb_seen = 0;
    fill(1, 0, IMG);
    check("pp_b_stb", stb_seen, IMG);
    check("pp_both_full", o_full, 1);
    check("pp_not_ready", o_ready, 0);
    rd(5, 1);
    check("pp_read_a", o_data, model(0, 5, 1));
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    check("pp_full_stays", o_full, 1);
    check("pp_ready_again", o_ready, 1);
    rd(5, 1);
    check("pp_read_b", o_data, model(1, 5, 1));
    rd(7, 0);
    check("pp_read_b2", o_data, model(1, 7, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
